// File: rtl/lbp_update_queue.sv
// lbp_update_queue: FIFO decoupling branch resolutions from the local branch predictor update port
//   clk_i, rst_ni      clock, async active-low reset
//   flush_bp_i         empties the queue at the next edge
//   debug_mode_i       ignores new resolutions, freezes and hides stored entries
//   resolved_i         resolved branch, pushed when .valid
//   bht_update_o       head entry toward the predictor, update_ready_i pops it
//   occupancy_o/full_o registered fill state; drop_cnt_o saturating overflow count
package lbp_update_queue_pkg;
  localparam int unsigned VLEN = 32;
  typedef struct packed {
    logic [7:0] index;
  } bht_meta_t;
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
    bht_meta_t       metadata;
  } bht_update_t;
endpackage

module lbp_update_queue #(
  parameter type         bht_update_t   = lbp_update_queue_pkg::bht_update_t,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_bp_i,
  input  logic                          debug_mode_i,
  input  bht_update_t                   resolved_i,
  output bht_update_t                   bht_update_o,
  input  logic                          update_ready_i,
  output logic [$clog2(DEPTH):0]        occupancy_o,
  output logic                          full_o,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;
  bht_update_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic out_valid, full, push_req, pop, push, drop;
  assign full      = occ_q == OW'(DEPTH);
  assign out_valid = occ_q != '0 && !debug_mode_i;
  assign push_req  = resolved_i.valid && !debug_mode_i && !flush_bp_i;
  // a flush cancels the pop even though the head is still presented this cycle
  assign pop       = out_valid && update_ready_i && !flush_bp_i;
  // when full, a same-cycle pop frees the slot the push lands in
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  always_comb begin
    rd_d   = flush_bp_i ? '0 : rd_q + PW'(pop);
    wr_d   = flush_bp_i ? '0 : wr_q + PW'(push);
    occ_d  = flush_bp_i ? '0 : occ_q + OW'(push) - OW'(pop);
    drop_d = (drop && drop_q != '1) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= resolved_i;
  end
  always_comb begin
    bht_update_o = '0;
    if (out_valid) begin
      bht_update_o       = mem_q[rd_q];
      bht_update_o.valid = 1'b1;
    end
  end
  assign occupancy_o = occ_q;
  assign full_o      = full;
  assign drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_lbp_update_queue.sv
// tb_lbp_update_queue: directed and random stimulus checked against a queue-based reference model
module tb_lbp_update_queue;
  import lbp_update_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int DW = 2;
  localparam int DMAX = (1 << DW) - 1;
  logic clk = 0, rst_n = 0, flush = 0, dbg = 0, rdy = 0;
  bht_update_t res = '0, upd;
  logic [2:0] occ;
  logic full;
  logic [DW-1:0] drops;
  int vectors = 0, errors = 0;
  bht_update_t mq[$];
  int mdrop = 0;
  always #5 clk = ~clk;
  lbp_update_queue #(.bht_update_t(bht_update_t), .DEPTH(DEPTH), .DROP_CNT_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_bp_i(flush), .debug_mode_i(dbg),
    .resolved_i(res), .bht_update_o(upd), .update_ready_i(rdy),
    .occupancy_o(occ), .full_o(full), .drop_cnt_o(drops)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic compare();
    bht_update_t e;
    e = '0;
    if (mq.size() != 0 && !dbg) begin
      e = mq[0];
      e.valid = 1'b1;
    end
    chk("bht_update", 64'(upd), 64'(e));
    chk("occupancy", 64'(occ), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("drop_cnt", 64'(drops), 64'(mdrop));
  endtask
  task automatic cyc(logic v, logic [31:0] pc, logic [7:0] ix, logic r, logic d, logic f);
    bht_update_t n;
    bit pop, preq;
    @(negedge clk);
    res.valid = v;
    res.pc = pc;
    res.taken = ix[0];
    res.metadata.index = ix;
    rdy = r;
    dbg = d;
    flush = f;
    #1 compare();
    pop = mq.size() != 0 && !d && r && !f;
    preq = v && !d && !f;
    if (f) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (preq) begin
        if (mq.size() < DEPTH) begin
          n = res;
          n.valid = 1'b0;
          mq.push_back(n);
        end else if (mdrop < DMAX) mdrop++;
      end
    end
  endtask
  task automatic push(logic [31:0] pc, logic [7:0] ix, logic r);
    cyc(1'b1, pc, ix, r, 1'b0, 1'b0);
  endtask
  task automatic idle(logic r);
    cyc(1'b0, 32'h0, 8'h0, r, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_update", 64'(upd), 64'(0));
    chk("rst_occupancy", 64'(occ), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_drop_cnt", 64'(drops), 64'(0));
    mq.delete();
    mdrop = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    do_reset();
    push(32'h8000_0010, 8'd5, 1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int i = 1; i <= 5; i++) push(32'h8000_0100 + 32'(i * 4), 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int i = 0; i < 4; i++) push(32'h8000_0200 + 32'(i * 4), 8'(16 + i), 1'b0);
    push(32'h8000_0300, 8'd40, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) push(32'h8000_0400 + 32'(i * 4), 8'(48 + i), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h8000_0500, 8'd60, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int i = 0; i < 3; i++) push(32'h8000_0600 + 32'(i * 4), 8'(64 + i), 1'b0);
    cyc(1'b1, 32'h8000_0700, 8'd70, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    push(32'h8000_0800, 8'd80, 1'b0);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 10; i++) push(32'h8000_0900 + 32'(i * 4), 8'(96 + i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    do_reset();
    idle(1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else cyc($urandom_range(9) < 6, $urandom, 8'($urandom), $urandom_range(1),
               $urandom_range(9) == 0, $urandom_range(31) == 0);
    end
    @(negedge clk);
    #1 compare();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
